data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path.sv | 167 ++++++++++++++++
 tb/tb_data_path.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// Datapath for the K-and-S processor: IR and decoder, 4x16 register file, ALU with
// registered flags, program counter and RAM address/data muxing.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;
endpackage

module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    logic [15:0] ir;
    logic [4:0]  pc;
    logic [15:0] regs [4];

    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [1:0]  sel_c;
    logic [15:0] bus_a;
    logic [15:0] bus_b;
    logic [15:0] bus_c;
    logic [15:0] alu_result;
    logic [16:0] add_full;
    logic [15:0] sub_result;
    logic        next_zero;
    logic        next_neg;
    logic        next_uovf;
    logic        next_sovf;

    // IR[7] carries no meaning in any instruction format.
    logic        unused_ir_bit;
    assign unused_ir_bit = ir[7];

    always_comb begin
        decoded_instruction = I_NOP;
        case (ir[15:8])
            8'h00:   decoded_instruction = I_NOP;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNZERO;
            8'h04:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BNNEG;
            8'h06:   decoded_instruction = I_BOV;
            8'h07:   decoded_instruction = I_BNOV;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE routes src onto both ports so an OR passes it through unchanged.
    always_comb begin
        sel_a = ir[3:2];
        sel_b = ir[1:0];
        sel_c = ir[6:5];
        case (decoded_instruction)
            I_MOVE: begin
                sel_a = ir[1:0];
                sel_c = ir[3:2];
            end
            I_ADD, I_SUB, I_AND, I_OR: sel_c = ir[5:4];
            default: sel_c = ir[6:5];
        endcase
    end

    assign bus_a    = regs[sel_a];
    assign bus_b    = regs[sel_b];
    assign data_out = regs[ir[6:5]];

    assign add_full   = {1'b0, bus_a} + {1'b0, bus_b};
    assign sub_result = bus_a - bus_b;

    always_comb begin
        alu_result = add_full[15:0];
        next_uovf  = 1'b0;
        next_sovf  = 1'b0;
        case (operation)
            2'b00: begin
                alu_result = add_full[15:0];
                next_uovf  = add_full[16];
                next_sovf  = (bus_a[15] == bus_b[15]) && (add_full[15] != bus_a[15]);
            end
            2'b01: begin
                alu_result = sub_result;
                next_uovf  = (bus_a < bus_b);
                next_sovf  = (bus_a[15] != bus_b[15]) && (sub_result[15] != bus_a[15]);
            end
            2'b10: alu_result = bus_a & bus_b;
            default: alu_result = bus_a | bus_b;
        endcase
    end

    assign next_zero = (alu_result == 16'h0000);
    assign next_neg  = alu_result[15];
    assign bus_c     = c_sel ? data_in : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_enable) begin
            ir <= data_in;
        end
    end

    // Branch target comes from the pre-edge IR even when the IR loads on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_enable) begin
            pc <= branch ? ir[4:0] : pc + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (write_reg_enable) begin
            regs[sel_c] <= bus_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= next_zero;
            neg_op            <= next_neg;
            unsigned_overflow <= next_uovf;
            signed_overflow   <= next_sovf;
        end
    end

    assign ram_addr = addr_sel ? pc : ir[4:0];

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: decode table, PC wrap/branch, register loads, ALU
// flags, write/read collision, flag hold and asynchronous reset.
module tb_data_path;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic                    flags_reg_enable;
    logic [1:0]              operation;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out;
    logic [15:0]             data_in;

    int tests = 0;
    int fails = 0;

    logic [7:0] opc_tab [17] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h55};
    logic [3:0] dec_tab [17] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .flags_reg_enable    (flags_reg_enable),
        .operation           (operation),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flags_now();
        return {12'h000, zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1'b1;
        step();
        ir_enable = 1'b0;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        set_ir({8'h81, 1'b0, r, 5'h00});
        data_in          = val;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        step();
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [1:0] r, input logic [15:0] exp);
        set_ir({8'h82, 1'b0, r, 5'h00});
        check(tag, data_out, exp);
    endtask

    task automatic alu(input logic [7:0] opc, input logic [7:0] low, input logic [1:0] op,
                       input logic fen);
        set_ir({opc, low});
        operation        = op;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        flags_reg_enable = fen;
        step();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
        write_reg_enable = 1'b0; addr_sel = 1'b1; c_sel = 1'b0;
        flags_reg_enable = 1'b0; operation = 2'b00; data_in = 16'h0000;
        #2;
        check("reset_pc", {11'h0, ram_addr}, 16'h0000);
        check("reset_dec", {12'h0, decoded_instruction}, 16'(I_NOP));
        check("reset_flags", flags_now(), 16'h0000);
        #11 rst_n = 1'b1;
        step();
        check("release_pc", {11'h0, ram_addr}, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            set_ir({opc_tab[i], 8'h00});
            check($sformatf("decode_%h", opc_tab[i]), {12'h0, decoded_instruction},
                  {12'h0, dec_tab[i]});
        end

        // Fetch path: branch to 31, increment wraps to 0, then fetch an ADD.
        set_ir(16'h011F);
        pc_enable = 1'b1; branch = 1'b1;
        step();
        check("pc_31", {11'h0, ram_addr}, 16'h001F);
        branch = 1'b0;
        step();
        pc_enable = 1'b0;
        check("pc_wrap", {11'h0, ram_addr}, 16'h0000);
        set_ir(16'hA11B);
        check("fetch_add", {12'h0, decoded_instruction}, 16'(I_ADD));

        set_ir(16'h0115);
        data_in = 16'h0107; ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b1;
        step();
        ir_enable = 1'b0;
        check("branch_pre_ir", {11'h0, ram_addr}, 16'h0015);
        step();
        pc_enable = 1'b0; branch = 1'b0;
        check("branch_new_ir", {11'h0, ram_addr}, 16'h0007);

        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        alu(8'hA1, 8'h06, 2'b00, 1'b1);
        check("add_sovf_flags", flags_now(), 16'h0005);
        read_reg("add_r0", 2'd0, 16'h8000);

        set_ir(16'h8253);
        addr_sel = 1'b0;
        #1;
        check("store_addr", {11'h0, ram_addr}, 16'h0013);
        check("store_data", data_out, 16'h0001);
        addr_sel = 1'b1;

        load_reg(2'd1, 16'h0000);
        alu(8'hA2, 8'h36, 2'b01, 1'b1);
        check("sub_borrow_flags", flags_now(), 16'h0006);
        read_reg("sub_r3", 2'd3, 16'hFFFF);
        alu(8'hA2, 8'h05, 2'b01, 1'b1);
        check("sub_zero_flags", flags_now(), 16'h0008);
        read_reg("sub_r0", 2'd0, 16'h0000);
        alu(8'hA1, 8'h0E, 2'b00, 1'b1);
        check("add_carry_flags", flags_now(), 16'h000A);

        // Write R3 while it drives data_out: old value this cycle, new one after the edge.
        set_ir(16'h8260);
        data_in = 16'h1234; c_sel = 1'b1; write_reg_enable = 1'b1;
        #1;
        check("collide_old", data_out, 16'hFFFF);
        step();
        c_sel = 1'b0; write_reg_enable = 1'b0;
        check("collide_new", data_out, 16'h1234);

        alu(8'hA1, 8'h06, 2'b00, 1'b0);
        check("flags_hold", flags_now(), 16'h000A);
        read_reg("hold_r0", 2'd0, 16'h0001);

        alu(8'h91, 8'h03, 2'b11, 1'b0);
        read_reg("move_r0", 2'd0, 16'h1234);
        alu(8'hA4, 8'h1E, 2'b11, 1'b1);
        check("or_flags", flags_now(), 16'h0000);
        read_reg("or_r1", 2'd1, 16'h1235);
        alu(8'hA3, 8'h1E, 2'b10, 1'b0);
        read_reg("and_r1", 2'd1, 16'h0000);
        alu(8'hA2, 8'h0B, 2'b01, 1'b1);
        check("sub_neg_flags", flags_now(), 16'h0006);
        read_reg("sub_r0b", 2'd0, 16'hEDCD);

        // Mid-cycle asynchronous reset with random strobes applied.
        set_ir(16'h0107);
        pc_enable = 1'b1; branch = 1'b1;
        step();
        #2;
        {branch, pc_enable, ir_enable, write_reg_enable, c_sel, flags_reg_enable} =
            6'($urandom_range(0, 63));
        operation = 2'($urandom_range(0, 3));
        data_in   = 16'($urandom);
        addr_sel  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_pc", {11'h0, ram_addr}, 16'h0000);
        check("async_dec", {12'h0, decoded_instruction}, 16'(I_NOP));
        check("async_flags", flags_now(), 16'h0000);
        check("async_r0", data_out, 16'h0000);
        addr_sel = 1'b0;
        #1;
        check("async_ir", {11'h0, ram_addr}, 16'h0000);
        step();
        #2;
        {branch, pc_enable, ir_enable, write_reg_enable, c_sel, flags_reg_enable} = 6'd0;
        addr_sel = 1'b1;
        rst_n = 1'b1;
        step();
        check("post_rst_pc", {11'h0, ram_addr}, 16'h0000);
        check("post_rst_flags", flags_now(), 16'h0000);
        pc_enable = 1'b1;
        step();
        pc_enable = 1'b0;
        check("post_rst_inc", {11'h0, ram_addr}, 16'h0001);
        read_reg("post_rst_r2", 2'd2, 16'h0000);
        read_reg("post_rst_r3", 2'd3, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
